fir_mac_filter: RTL and testbench

- Time-multiplexed, single-multiplier FIR low-pass stage placed directly upstream of the echo stage.
- Accepts one signed 16-bit audio sample per sample strobe and runs TAPS multiply-accumulate cycles on the fast system clock.
- Registers a rounded, saturated 16-bit result that feeds the echo stage's input_sample. The result is held stable between updates, so the echo stage can sample it on its own sample clock.

---
 rtl/fir_mac_filter_pkg.sv | 27 ++
 rtl/fir_mac_filter_if.sv | 29 ++
 rtl/fir_round_sat.sv | 30 +++
 rtl/fir_mac_filter.sv | 106 ++++++++++
 tb/tb_fir_mac_filter.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fir_mac_filter_pkg.sv
// rtl/fir_mac_filter_pkg.sv - Q-format constants, FSM states and coefficient tables for the FIR stage
package fir_pkg;

    localparam int COEF_FRAC   = 15;
    localparam int ROUND_CONST = 16384;
    localparam int SAT_MAX     = 32767;
    localparam int SAT_MIN     = -32768;
    localparam int MAX_TAPS    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Tables are sized for the largest supported TAPS; shorter filters use the head.
    localparam logic signed [15:0] COEF_AVG [MAX_TAPS] = '{default: 16'sd2048};
    localparam logic signed [15:0] COEF_GAIN [MAX_TAPS] =
        '{0: 16'sd32767, 1: 16'sd32767, default: 16'sd0};

    function automatic logic signed [15:0] coef(input int set, input logic [5:0] k);
        if (set == 1)
            return COEF_GAIN[k];
        return COEF_AVG[k];
    endfunction

endpackage

// File: rtl/fir_mac_filter_if.sv
// rtl/fir_mac_filter_if.sv - sample strobe and filtered-output bundle for the FIR stage
interface fir_mac_filter_if #(
    parameter int DATA_W = 16
);
    logic                     sample_valid;
    logic signed [DATA_W-1:0] input_sample;
    logic signed [DATA_W-1:0] output_sample;
    logic                     output_valid;
    logic                     busy;
    logic                     overrun;

    modport master (
        output sample_valid,
        output input_sample,
        input  output_sample,
        input  output_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  sample_valid,
        input  input_sample,
        output output_sample,
        output output_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up, shift out the Q1.15 fraction and clamp to the sample range
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W  = 36,
    parameter int DATA_W = 16
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] sample
);

    localparam logic signed [ACC_W:0] HI = (ACC_W + 1)'(SAT_MAX);
    localparam logic signed [ACC_W:0] LO = (ACC_W + 1)'(SAT_MIN);

    logic signed [ACC_W:0] rounded;
    logic signed [ACC_W:0] shifted;

    // One extra bit keeps the rounding add from wrapping at the top of the range.
    assign rounded = (ACC_W + 1)'(acc) + (ACC_W + 1)'(ROUND_CONST);
    assign shifted = rounded >>> COEF_FRAC;

    always_comb begin
        sample = DATA_W'(shifted);
        if (shifted > HI)
            sample = DATA_W'(SAT_MAX);
        else if (shifted < LO)
            sample = DATA_W'(SAT_MIN);
    end

endmodule

// File: rtl/fir_mac_filter.sv
// rtl/fir_mac_filter.sv - single-multiplier time-multiplexed FIR low-pass feeding the echo stage
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int TAPS     = 16,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int COEF_SET = 0
) (
    input logic            clock,
    input logic            reset,
    fir_mac_filter_if.slave bus
);

    localparam int PTR_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + PTR_W;

    state_t state;
    state_t state_next;

    logic signed [DATA_W-1:0] line [TAPS];
    logic        [PTR_W-1:0]  wptr;
    logic        [PTR_W-1:0]  k;
    logic        [PTR_W-1:0]  rd_idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [COEF_W-1:0] c_k;
    logic signed [PROD_W-1:0] product;
    logic signed [DATA_W-1:0] result;
    logic signed [DATA_W-1:0] out_sample;
    logic                     out_valid;
    logic                     overrun_flag;

    // Power-of-two TAPS lets the pointer subtraction wrap on its own.
    assign rd_idx  = wptr - k;
    assign c_k     = COEF_W'(coef(COEF_SET, 6'(k)));
    assign product = line[rd_idx] * c_k;

    fir_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_round_sat (
        .acc    (acc),
        .sample (result)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.sample_valid) state_next = MAC;
            MAC:     if (k == PTR_W'(TAPS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++)
                line[i] <= '0;
            wptr         <= '0;
            k            <= '0;
            acc          <= '0;
            out_sample   <= '0;
            out_valid    <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        line[wptr] <= bus.input_sample;
                        acc        <= '0;
                        k          <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(product);
                    k   <= k + 1'b1;
                end
                DONE: begin
                    out_sample <= result;
                    out_valid  <= 1'b1;
                    wptr       <= wptr + 1'b1;
                end
                default: ;
            endcase
            // Strobes during a computation are dropped but remembered until reset.
            if (state != IDLE && bus.sample_valid)
                overrun_flag <= 1'b1;
        end
    end

    assign bus.output_sample = out_sample;
    assign bus.output_valid  = out_valid;
    assign bus.busy          = (state != IDLE);
    assign bus.overrun       = overrun_flag;

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb/tb_fir_mac_filter.sv - randomized and directed bench for both coefficient sets against an arithmetic model
module tb_fir_mac_filter;

    localparam int TAPS = 16;

    logic clk;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    int   hist[$];

    fir_mac_filter_if #(.DATA_W(16)) if0 ();
    fir_mac_filter_if #(.DATA_W(16)) if1 ();

    fir_mac_filter #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .COEF_SET(0)) dut0 (
        .clock (clk),
        .reset (rst),
        .bus   (if0.slave)
    );

    fir_mac_filter #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .COEF_SET(1)) dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_coef(input int set, input int k);
        if (set == 0) return 2048;
        return (k < 2) ? 32767 : 0;
    endfunction

    // y[n] = sat(round(sum x[n-k]*c[k] / 2^15)); hist[0] is the newest accepted sample.
    function automatic int model(input int set);
        longint sum = 0;
        longint y;
        for (int k = 0; k < TAPS; k++)
            if (k < hist.size()) sum += longint'(hist[k]) * ref_coef(set, k);
        y = (sum + 16384) >>> 15;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    task automatic drive(input logic v, input logic [15:0] x);
        if0.sample_valid = v;
        if1.sample_valid = v;
        if0.input_sample = x;
        if1.input_sample = x;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        hist.delete();
        check("rst_out0", int'(if0.output_sample), 0);
        check("rst_out1", int'(if1.output_sample), 0);
        check("rst_valid", int'(if0.output_valid | if1.output_valid), 0);
        check("rst_busy", int'(if0.busy | if1.busy), 0);
        check("rst_overrun", int'(if0.overrun | if1.overrun), 0);
    endtask

    // Strobe one sample, wait for the result and compare both sets against the model.
    task automatic apply(input logic [15:0] x, input string tag);
        logic signed [15:0] xs;
        int n;
        xs = x;
        drive(1'b1, x);
        @(posedge clk);
        #1 drive(1'b0, 16'h0);
        hist.push_front(int'(xs));
        if (hist.size() > TAPS) void'(hist.pop_back());
        check({tag, "_busy"}, int'(if0.busy), 1);
        n = 0;
        while (!if0.output_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_latency"}, n, TAPS + 1);
        check({tag, "_valid1"}, int'(if1.output_valid), 1);
        check({tag, "_y0"}, int'(if0.output_sample), model(0));
        check({tag, "_y1"}, int'(if1.output_sample), model(1));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0);
        do_reset();

        // Aborted computation must leave no trace in the delay line or pointer.
        apply(16'h1234, "pre");
        drive(1'b1, 16'h7000);
        @(posedge clk);
        #1 drive(1'b0, 16'h0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        hist.delete();
        check("abort_valid", int'(if0.output_valid), 0);
        check("abort_busy", int'(if0.busy), 0);
        check("abort_out", int'(if0.output_sample), 0);
        begin
            int seen = 0;
            repeat (TAPS + 4) begin
                @(posedge clk);
                #1 if (if0.output_valid || if1.output_valid) seen++;
            end
            check("abort_no_valid", seen, 0);
        end

        apply(16'h4000, "imp");
        for (int i = 0; i < 20; i++) apply(16'h0000, "imp0");

        do_reset();
        for (int i = 0; i < 18; i++) apply(16'h7FFF, "dc");

        do_reset();
        for (int i = 0; i < 4; i++) apply(16'h6000, "satp");
        do_reset();
        for (int i = 0; i < 4; i++) apply(16'hA000, "satn");
        do_reset();
        apply(16'hFFFF, "neg1");
        for (int i = 0; i < 3; i++) apply(16'h0000, "neg1z");

        // Overrun: strobes at accept+3 and in the DONE cycle are both dropped.
        do_reset();
        drive(1'b1, 16'h2000);
        @(posedge clk);
        #1 drive(1'b0, 16'h0);
        hist.push_front(int'(16'sh2000));
        repeat (2) @(posedge clk);
        #1 drive(1'b1, 16'h7FFF);
        @(posedge clk);
        #1 drive(1'b0, 16'h0);
        check("ovr_set", int'(if0.overrun), 1);
        repeat (TAPS - 3) @(posedge clk);
        #1 drive(1'b1, 16'h5555);
        @(posedge clk);
        #1 drive(1'b0, 16'h0);
        check("ovr_done_valid", int'(if0.output_valid), 1);
        check("ovr_y0", int'(if0.output_sample), model(0));
        check("ovr_y1", int'(if1.output_sample), model(1));
        apply(16'h1000, "ovr_next");
        check("ovr_sticky", int'(if0.overrun & if1.overrun), 1);

        do_reset();
        for (int i = 0; i < 30; i++) apply(16'($urandom), "rnd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
